// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester/transmitter signal bundle for the arbiter  |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  active_ch;
  logic        idle;
  logic        err_timeout;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_data, tx_start, active_ch, idle, err_timeout
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_data, tx_start, active_ch, idle, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter : 4-way round-robin arbiter feeding one UART transmitter   |
// | Option: UART_ARB_TAG_EN sends tag byte 8'hA0|ch before each data byte      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uart_tx_arbiter_if.master arb_io
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_HI   = 3'd2,
    WAIT_LO   = 3'd3,
    TAG_START = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;
`endif

  localparam logic [4:0] c_timeout_last = 5'(BUSY_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] last_ch_q, last_ch_d;
  logic [1:0] active_ch_q, active_ch_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [3:0] ack_q, ack_d;
  logic       tx_start_q, tx_start_d;
  logic [4:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`ifdef UART_ARB_TAG_EN
  logic [7:0] data_q, data_d;
  logic       tag_phase_q, tag_phase_d;
`endif

  logic       w_grant_vld;
  logic [1:0] w_grant_ch;
  logic [7:0] w_grant_byte;

  // Scan from farthest to nearest so the nearest pending channel after last_ch wins.
  always_comb begin
    logic [1:0] cand;
    w_grant_vld = 1'b0;
    w_grant_ch  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_ch_q + 2'(k);
      if (arb_io.req[cand]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = cand;
      end
    end
  end

  assign w_grant_byte = arb_io.req_data[{w_grant_ch, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    last_ch_d   = last_ch_q;
    active_ch_d = active_ch_q;
    tx_data_d   = tx_data_q;
    ack_d       = 4'b0000;
    tx_start_d  = 1'b0;
    cnt_d       = cnt_q;
    err_d       = err_q;
`ifdef UART_ARB_TAG_EN
    data_d      = data_q;
    tag_phase_d = tag_phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_grant_vld && !arb_io.tx_busy) begin
          last_ch_d   = w_grant_ch;
          active_ch_d = w_grant_ch;
          ack_d       = 4'(4'b0001 << w_grant_ch);
`ifdef UART_ARB_TAG_EN
          tx_data_d   = 8'hA0 | {6'b000000, w_grant_ch};
          data_d      = w_grant_byte;
          tag_phase_d = 1'b1;
          state_d     = TAG_START;
`else
          tx_data_d   = w_grant_byte;
          state_d     = START;
`endif
        end
      end
      // The strobe is registered, so it shows in the cycle after START (ack+1).
      START: begin
        tx_start_d = 1'b1;
        cnt_d      = 5'd0;
        state_d    = WAIT_HI;
      end
`ifdef UART_ARB_TAG_EN
      TAG_START: begin
        tx_start_d = 1'b1;
        cnt_d      = 5'd0;
        state_d    = WAIT_HI;
      end
`endif
      WAIT_HI: begin
        if (arb_io.tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == c_timeout_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef UART_ARB_TAG_EN
          tag_phase_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WAIT_LO: begin
        if (!arb_io.tx_busy) begin
`ifdef UART_ARB_TAG_EN
          if (tag_phase_q) begin
            tag_phase_d = 1'b0;
            tx_data_d   = data_q;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_ch_q   <= 2'd3;
      active_ch_q <= 2'd0;
      tx_data_q   <= 8'h00;
      ack_q       <= 4'b0000;
      tx_start_q  <= 1'b0;
      cnt_q       <= 5'd0;
      err_q       <= 1'b0;
`ifdef UART_ARB_TAG_EN
      data_q      <= 8'h00;
      tag_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_ch_q   <= last_ch_d;
      active_ch_q <= active_ch_d;
      tx_data_q   <= tx_data_d;
      ack_q       <= ack_d;
      tx_start_q  <= tx_start_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`ifdef UART_ARB_TAG_EN
      data_q      <= data_d;
      tag_phase_q <= tag_phase_d;
`endif
    end
  end

  assign arb_io.ack         = ack_q;
  assign arb_io.tx_data     = tx_data_q;
  assign arb_io.tx_start    = tx_start_q;
  assign arb_io.active_ch   = active_ch_q;
  assign arb_io.idle        = (state_q == IDLE);
  assign arb_io.err_timeout = err_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have the parameter BUSY_TIMEOUT, default 16, giving the maximum cycles to wait for tx_busy rising after tx_start.
REQ-002 The block SHALL have the port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port req, input, 4 bits: req[i] high means requester i has a byte pending.
REQ-005 The block SHALL have the port req_data, input, 32 bits: requester i's byte on bits [8i+7:8i].
REQ-006 The block SHALL have the port ack, output, 4 bits: one-cycle pulse on ack[i] when requester i's byte is captured.
REQ-007 The block SHALL have the port tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-008 The block SHALL have the port tx_start, output, 1 bit: one-cycle transmit strobe.
REQ-009 The block SHALL have the port tx_busy, input, 1 bit: transmitter busy flag.
REQ-010 The block SHALL have the port active_ch, output, 2 bits: index of the channel being served.
REQ-011 The block SHALL have the port idle, output, 1 bit: high only when the FSM is in IDLE.
REQ-012 The block SHALL have the port err_timeout, output, 1 bit: sticky flag set when tx_busy never rose.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, START, WAIT_HI, WAIT_LO (plus TAG_START when the tag feature is compiled in).
REQ-014 In IDLE, when any req bit is high and tx_busy=0, the block SHALL grant one channel on the next edge.
- Grant latches req_data byte into tx_data, sets active_ch, pulses ack[ch] for one cycle.
- Next state: START, or TAG_START when the tag feature is compiled in.
REQ-015 Arbitration SHALL be round-robin: search order last_ch+1, +2, +3, +4, all mod 4; last_ch updates to the granted channel.
REQ-016 No grant SHALL occur while tx_busy=1 in IDLE; requests wait and no ack is issued.
REQ-017 In START, tx_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_HI.
REQ-018 Latency SHALL be: req sampled high in IDLE at cycle N -> ack high at cycle N+1 -> tx_start high at cycle N+2.
REQ-019 In WAIT_HI, tx_busy=1 SHALL move the FSM to WAIT_LO.
- A 5-bit counter reaching BUSY_TIMEOUT sets err_timeout and returns the FSM to IDLE.
REQ-020 In WAIT_LO, tx_busy=0 SHALL return the FSM to IDLE; there is no timeout in WAIT_LO.
REQ-021 tx_data SHALL remain stable from capture until the FSM re-enters IDLE.
REQ-022 At most one ack bit SHALL be high in any cycle, and ack SHALL never be high outside the capture cycle.
REQ-023 Requesters SHALL drop req, or present new data, in the cycle after ack; since the FSM is not in IDLE then, no double grant is possible.
REQ-024 A req deasserted before grant SHALL simply not be served; no error is raised.
REQ-025 Once set, err_timeout SHALL remain 1 until reset.

Reset
REQ-026 While rst=1, asynchronously, the following SHALL hold:
- ack=0, tx_start=0, tx_data=8'h00, active_ch=0, idle=1, err_timeout=0.
- State=IDLE, last_ch=3 (channel 0 has first priority).
REQ-027 Reset mid-transfer SHALL discard the captured byte, drop tx_start immediately, and issue no ack after release.
REQ-028 The first grant SHALL be possible on the first edge at which rst is low.

Configuration
REQ-029 With macro UART_ARB_TAG_EN defined, each grant SHALL transmit a tag byte 8'hA0|{6'b0,ch} before the data byte.
- Tag path: TAG_START -> WAIT_HI -> WAIT_LO -> START, followed by the normal data byte sequence.
- ack is still issued once, at capture.
REQ-030 With UART_ARB_TAG_EN undefined, there SHALL be no TAG_START state, and exactly one byte is transmitted per grant.

Verification
REQ-031 Single request: req=4'b0001, req_data[7:0]=8'h55, model busy 1 cycle after start for 10 cycles -> ack=0001 at N+1, tx_start at N+2 with tx_data=8'h55, idle=1 after tx_busy falls.
REQ-032 Contention: req=4'b1111 held with data 11,22,33,44 -> transmit order 8'h11, 22, 33, 44, 11; each ack exactly once per byte.
REQ-033 Busy blocking: tx_busy=1 externally with req=4'b0100 -> no ack; release tx_busy -> ack=0100 one cycle later.
REQ-034 Timeout: tx_busy tied 0, req=4'b0010 -> err_timeout=1 after 16 cycles in WAIT_HI, FSM returns to IDLE, next request still served.
REQ-035 Reset during WAIT_LO: assert rst -> tx_start=0, idle=1, ack=0 immediately; after release with req=4'b1000, channel 3 is granted.
REQ-036 With UART_ARB_TAG_EN, req=4'b0100, data 8'h7E -> tx_data sequence 8'hA2 then 8'h7E, two tx_start pulses, one ack.
